nf_pipe_ctrl: RTL and testbench

NF_PIPE_CTRL -- requirements
Module: nf_pipe_ctrl

---
 rtl/nf_pipe_ctrl_pkg.sv | 40 ++++
 rtl/nf_sat_cnt.sv | 21 ++
 rtl/nf_pipe_ctrl.sv | 120 ++++++++++++
 tb/tb_nf_pipe_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/nf_pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Control vectors are packed in pipeline order, stalls first, then flushes, then abort.
package nf_pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_MEM_ERR  = 2'd2
    } state_t;

    typedef struct packed {
        logic stall_if;
        logic stall_id;
        logic stall_iexe;
        logic stall_imem;
        logic flush_id;
        logic flush_iexe;
        logic flush_imem;
        logic flush_iwb;
        logic dm_abort;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE      = ctrl_t'(9'b0000_0000_0);
    localparam ctrl_t CTRL_LW        = ctrl_t'(9'b1100_0100_0);
    localparam ctrl_t CTRL_BRANCH    = ctrl_t'(9'b0000_1000_0);
    localparam ctrl_t CTRL_MEM_STALL = ctrl_t'(9'b1111_0001_0);
    localparam ctrl_t CTRL_MEM_ERR   = ctrl_t'(9'b0000_0011_1);

    // Load-use hazard takes priority; the branch resolves again once the stall clears.
    function automatic ctrl_t normal_eval(input logic lw_hazard, input logic branch_taken);
        ctrl_t c;
        c = CTRL_NONE;
        if (lw_hazard)
            c = CTRL_LW;
        else if (branch_taken)
            c = CTRL_BRANCH;
        return c;
    endfunction

endpackage

// File: rtl/nf_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module nf_sat_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && (cnt != {W{1'b1}}))
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/nf_pipe_ctrl.sv
// Pipeline stall/flush controller with data-memory timeout and stall-cycle counter.
//   state       | meaning
//   ST_RUN      | normal issue; hazard/branch handling, starts a stalled memory access
//   ST_MEM_WAIT | memory access outstanding; pipeline held until ack or timeout
//   ST_MEM_ERR  | one-cycle abort of the hung access, MEM/WB bubbled
module nf_pipe_ctrl
    import nf_pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lw_hazard,
    input  logic             branch_taken,
    input  logic             dm_req,
    input  logic             dm_ack,
    input  logic             err_clr,
    input  logic             cnt_clr,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_iexe,
    output logic             stall_imem,
    output logic             flush_id,
    output logic             flush_iexe,
    output logic             flush_imem,
    output logic             flush_iwb,
    output logic             dm_abort,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int WCW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

    state_t         state;
    logic [WCW-1:0] wait_cnt;
    ctrl_t          ctrl;
    logic           to_set;

    assign to_set = (state == ST_MEM_WAIT) && !dm_ack && (wait_cnt == WAIT_LAST);

    // Outputs are forced quiet while reset is held, even if inputs are active.
    always_comb begin
        ctrl = CTRL_NONE;
        if (!rst) begin
            case (state)
                ST_RUN:      ctrl = (dm_req && !dm_ack) ? CTRL_MEM_STALL
                                                        : normal_eval(lw_hazard, branch_taken);
                ST_MEM_WAIT: ctrl = dm_ack ? normal_eval(lw_hazard, branch_taken)
                                           : CTRL_MEM_STALL;
                ST_MEM_ERR:  ctrl = CTRL_MEM_ERR;
                default:     ctrl = CTRL_NONE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (dm_req && !dm_ack) begin
                        state    <= ST_MEM_WAIT;
                        wait_cnt <= WCW'(1);
                    end
                end
                ST_MEM_WAIT: begin
                    if (dm_ack) begin
                        state    <= ST_RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state <= ST_MEM_ERR;
                    end else begin
                        wait_cnt <= wait_cnt + WCW'(1);
                    end
                end
                ST_MEM_ERR: begin
                    state    <= ST_RUN;
                    wait_cnt <= '0;
                end
                default: begin
                    state    <= ST_RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    // A timeout landing on the same edge as a clear must remain visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            mem_timeout <= 1'b0;
        else if (to_set)
            mem_timeout <= 1'b1;
        else if (err_clr)
            mem_timeout <= 1'b0;
    end

    nf_sat_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (ctrl.stall_if),
        .clr (cnt_clr),
        .cnt (stall_cnt)
    );

    assign stall_if   = ctrl.stall_if;
    assign stall_id   = ctrl.stall_id;
    assign stall_iexe = ctrl.stall_iexe;
    assign stall_imem = ctrl.stall_imem;
    assign flush_id   = ctrl.flush_id;
    assign flush_iexe = ctrl.flush_iexe;
    assign flush_imem = ctrl.flush_imem;
    assign flush_iwb  = ctrl.flush_iwb;
    assign dm_abort   = ctrl.dm_abort;

endmodule

// File: tb/tb_nf_pipe_ctrl.sv
// Directed bench for nf_pipe_ctrl with MEM_TIMEOUT=4; a second instance with CNT_W=3
// exercises counter saturation.
module tb_nf_pipe_ctrl;

    localparam logic [8:0] E_N  = 9'b0000_0000_0;
    localparam logic [8:0] E_LW = 9'b1100_0100_0;
    localparam logic [8:0] E_BR = 9'b0000_1000_0;
    localparam logic [8:0] E_MS = 9'b1111_0001_0;
    localparam logic [8:0] E_ME = 9'b0000_0011_1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic lw_hazard = 1'b0, branch_taken = 1'b0, dm_req = 1'b0, dm_ack = 1'b0;
    logic err_clr = 1'b0, cnt_clr = 1'b0;
    logic s_if, s_id, s_iexe, s_imem, f_id, f_iexe, f_imem, f_iwb, abort, mto;
    logic [31:0] cnt;
    logic [8:0]  ctrl;

    logic lw2 = 1'b0, cnt_clr2 = 1'b0;
    logic s2_if, s2_id, s2_iexe, s2_imem, f2_id, f2_iexe, f2_imem, f2_iwb, abort2, mto2;
    logic [2:0] cnt2;

    typedef struct packed {
        logic [8:0]  ctrl;
        logic [31:0] cnt;
        logic        to;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   m_cnt = 0;
    int   m2    = 0;

    always #5 clk = ~clk;

    nf_pipe_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .lw_hazard(lw_hazard), .branch_taken(branch_taken),
        .dm_req(dm_req), .dm_ack(dm_ack), .err_clr(err_clr), .cnt_clr(cnt_clr),
        .stall_if(s_if), .stall_id(s_id), .stall_iexe(s_iexe), .stall_imem(s_imem),
        .flush_id(f_id), .flush_iexe(f_iexe), .flush_imem(f_imem), .flush_iwb(f_iwb),
        .dm_abort(abort), .mem_timeout(mto), .stall_cnt(cnt)
    );

    nf_pipe_ctrl #(.MEM_TIMEOUT(4), .CNT_W(3)) dut2 (
        .clk(clk), .rst(rst), .lw_hazard(lw2), .branch_taken(1'b0),
        .dm_req(1'b0), .dm_ack(1'b0), .err_clr(1'b0), .cnt_clr(cnt_clr2),
        .stall_if(s2_if), .stall_id(s2_id), .stall_iexe(s2_iexe), .stall_imem(s2_imem),
        .flush_id(f2_id), .flush_iexe(f2_iexe), .flush_imem(f2_imem), .flush_iwb(f2_iwb),
        .dm_abort(abort2), .mem_timeout(mto2), .stall_cnt(cnt2)
    );

    assign ctrl = {s_if, s_id, s_iexe, s_imem, f_id, f_iexe, f_imem, f_iwb, abort};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs at negedge, queue the expectation, compare before the next edge.
    task automatic step(input string tag, input logic lw, input logic br, input logic req,
                        input logic ack, input logic eclr, input logic cclr,
                        input logic [8:0] exp_ctrl, input logic exp_to);
        exp_t e;
        exp_t got;
        @(negedge clk);
        lw_hazard = lw; branch_taken = br; dm_req = req; dm_ack = ack;
        err_clr = eclr; cnt_clr = cclr;
        e.ctrl = exp_ctrl;
        e.cnt  = 32'(m_cnt);
        e.to   = exp_to;
        sbq.push_back(e);
        if (cclr)
            m_cnt = 0;
        else if (exp_ctrl[8])
            m_cnt++;
        #1;
        got = sbq.pop_front();
        check({tag, "/ctrl"}, 32'(ctrl), 32'(got.ctrl));
        check({tag, "/cnt"}, cnt, got.cnt);
        check({tag, "/to"}, 32'(mto), 32'(got.to));
    endtask

    initial begin
        // held in reset with active inputs
        lw_hazard = 1'b1; dm_req = 1'b1; branch_taken = 1'b1;
        #3;
        check("rst/ctrl", 32'(ctrl), 32'(E_N));
        check("rst/cnt", cnt, 32'd0);
        check("rst/to", 32'(mto), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        lw_hazard = 1'b0; dm_req = 1'b0; branch_taken = 1'b0;

        step("lw_br",   1, 1, 0, 0, 0, 0, E_LW, 0);
        step("idle0",   0, 0, 0, 0, 0, 0, E_N,  0);
        step("br",      0, 1, 0, 0, 0, 0, E_BR, 0);

        // access acked on the third cycle
        step("ack_s1",  0, 1, 1, 0, 0, 0, E_MS, 0);
        step("ack_s2",  1, 0, 1, 0, 0, 0, E_MS, 0);
        step("ack_a",   0, 0, 1, 1, 0, 0, E_N,  0);
        step("ack_run", 0, 1, 0, 0, 0, 0, E_BR, 0);
        step("reqack",  0, 0, 1, 1, 0, 0, E_N,  0);
        step("reqack2", 1, 0, 0, 0, 0, 0, E_LW, 0);

        // access never acked
        step("to1_s1",  0, 0, 1, 0, 0, 0, E_MS, 0);
        step("to1_s2",  0, 0, 1, 0, 0, 0, E_MS, 0);
        step("to1_s3",  0, 1, 1, 0, 0, 0, E_MS, 0);
        step("to1_s4",  1, 0, 1, 0, 0, 0, E_MS, 0);
        step("to1_err", 1, 1, 1, 1, 0, 0, E_ME, 1);
        step("to1_run", 0, 1, 0, 0, 0, 0, E_BR, 1);
        step("to1_hold",0, 0, 0, 0, 0, 0, E_N,  1);
        step("to1_clr", 0, 0, 0, 0, 1, 0, E_N,  1);
        step("to1_gone",0, 0, 0, 0, 0, 0, E_N,  0);

        // err_clr coincides with the timeout edge
        step("to2_s1",  0, 0, 1, 0, 0, 0, E_MS, 0);
        step("to2_s2",  0, 0, 1, 0, 0, 0, E_MS, 0);
        step("to2_s3",  0, 0, 1, 0, 0, 0, E_MS, 0);
        step("to2_s4",  0, 0, 1, 0, 1, 0, E_MS, 0);
        step("to2_err", 0, 0, 0, 0, 0, 0, E_ME, 1);
        step("to2_hold",0, 0, 0, 0, 0, 0, E_N,  1);

        // counter clear wins over a stall in the same cycle
        step("cclr",    1, 0, 0, 0, 0, 1, E_LW, 1);
        step("cclr_z",  0, 0, 0, 0, 0, 0, E_N,  1);

        // reset pulse in the second MEM_WAIT cycle
        step("rs_s1",   0, 0, 1, 0, 0, 0, E_MS, 1);
        step("rs_s2",   0, 0, 1, 0, 0, 0, E_MS, 1);
        step("rs_s3",   1, 0, 1, 0, 0, 0, E_MS, 1);
        #2 rst = 1'b1;
        #1;
        check("midrst/ctrl", 32'(ctrl), 32'(E_N));
        check("midrst/cnt", cnt, 32'd0);
        check("midrst/to", 32'(mto), 32'd0);
        m_cnt = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        step("post_rst",0, 1, 0, 0, 0, 0, E_BR, 0);
        step("post_rs2",0, 0, 1, 1, 0, 0, E_N,  0);

        // narrow counter saturates at 7
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            lw2 = 1'b1; cnt_clr2 = 1'b0;
            #1;
            check("sat/stall", 32'(s2_if), 32'd1);
            check("sat/cnt", 32'(cnt2), 32'(m2));
            m2 = (m2 == 7) ? 7 : m2 + 1;
        end
        @(negedge clk);
        lw2 = 1'b1; cnt_clr2 = 1'b1;
        #1 check("sat/pre_clr", 32'(cnt2), 32'(m2));
        @(negedge clk);
        lw2 = 1'b0; cnt_clr2 = 1'b0;
        #1 check("sat/clr", 32'(cnt2), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
